// File: rtl/comp_serial_ctrl.sv
// comp_serial_ctrl: MSB-first serial magnitude compare using one 2-bit slice per clock, early exit on first unequal slice.
// Define COMP_SIGNED_EN to compare operands as two's complement.
module comp_serial_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic                             start,
  input  logic [WIDTH-1:0]                 A,
  input  logic [WIDTH-1:0]                 B,
  output logic                             busy,
  output logic                             done,
  output logic                             A_gt_B,
  output logic                             A_lt_B,
  output logic                             A_eq_B,
  output logic [$clog2(WIDTH/2+1)-1:0]     slices_used
);
  localparam int NS = WIDTH / 2;
  localparam int KW = NS > 1 ? $clog2(NS) : 1;
  localparam int SW = $clog2(NS + 1);
  typedef enum logic [1:0] {IDLE, COMPARE, DONE} state_t;
  state_t r_state, w_next;
  logic [WIDTH-1:0] r_a, r_b;
  logic [KW-1:0] r_k;
  logic [1:0] w_a, w_b;
  logic w_lt_u, w_eq, w_lt, w_gt, w_fin;
  assign w_a = r_a[{r_k, 1'b0} +: 2];
  assign w_b = r_b[{r_k, 1'b0} +: 2];
  assign w_lt_u = (!w_a[1] & w_b[1]) | (!w_a[1] & !w_a[0] & w_b[0]) | (!w_a[0] & w_b[0] & w_b[1]);
  assign w_eq = (w_a[1] ~^ w_b[1]) & (w_a[0] ~^ w_b[0]);
`ifdef COMP_SIGNED_EN
  // Sign bits differ in the top slice: the negative operand is the smaller one.
  logic w_sgn;
  assign w_sgn = (r_k == KW'(NS - 1)) && (w_a[1] != w_b[1]);
  assign w_lt = w_sgn ? w_a[1] : w_lt_u;
  assign w_gt = w_sgn ? w_b[1] : !(w_lt_u | w_eq);
`else
  assign w_lt = w_lt_u;
  assign w_gt = !(w_lt_u | w_eq);
`endif
  assign w_fin = !w_eq || (r_k == '0);
  assign busy = r_state != IDLE;
  assign done = r_state == DONE;
  always_comb begin
    w_next = r_state;
    w_next = (r_state == IDLE)    ? (start ? COMPARE : IDLE) :
             (r_state == COMPARE) ? (w_fin ? DONE : COMPARE) : IDLE;
  end
  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      r_a <= '0;
      r_b <= '0;
      r_k <= '0;
      A_gt_B <= 1'b0;
      A_lt_B <= 1'b0;
      A_eq_B <= 1'b0;
      slices_used <= '0;
    end else begin
      if (r_state == IDLE && start) begin
        r_a <= A;
        r_b <= B;
        r_k <= KW'(NS - 1);
      end
      if (r_state == COMPARE) begin
        if (w_fin) begin
          A_gt_B <= w_gt;
          A_lt_B <= w_lt;
          A_eq_B <= w_eq;
          slices_used <= SW'(NS) - SW'(r_k);
        end else r_k <= r_k - KW'(1);
      end
    end
  end
endmodule

// File: tb/tb_comp_serial_ctrl.sv
// tb_comp_serial_ctrl: directed checks of the serial comparator handshake, latency and results.
module tb_comp_serial_ctrl;
  logic clock = 0, reset = 0, start = 0;
  logic [7:0] A = 0, B = 0;
  logic busy, done, A_gt_B, A_lt_B, A_eq_B;
  logic [2:0] slices_used;
  int n_checks = 0, n_errors = 0;
  comp_serial_ctrl #(.WIDTH(8)) dut (
    .clock(clock), .reset(reset), .start(start), .A(A), .B(B),
    .busy(busy), .done(done), .A_gt_B(A_gt_B), .A_lt_B(A_lt_B),
    .A_eq_B(A_eq_B), .slices_used(slices_used)
  );
  always #5 clock = ~clock;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic edge1();
    @(posedge clock);
    #1;
  endtask
  // flags packed as {gt,lt,eq}
  task automatic run_cmp(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] flags, input int n);
    int cnt;
    @(negedge clock);
    A = a; B = b; start = 1;
    edge1();
    start = 0;
    check({tag, "_busy_accept"}, busy, 1);
    cnt = 0;
    while (!done && cnt < 10) begin
      edge1();
      cnt++;
    end
    check({tag, "_latency"}, cnt, n);
    check({tag, "_busy_done"}, busy, 1);
    check({tag, "_flags"}, {A_gt_B, A_lt_B, A_eq_B}, flags);
    check({tag, "_slices"}, slices_used, n);
    edge1();
    check({tag, "_idle"}, {busy, done}, 2'b00);
    check({tag, "_hold"}, {A_gt_B, A_lt_B, A_eq_B, slices_used}, {flags, 3'(n)});
  endtask
  initial begin
    int dones;
    reset = 1; start = 1; A = 8'hFF; B = 8'h00;
    edge1();
    edge1();
    check("reset", {busy, done, A_gt_B, A_lt_B, A_eq_B, slices_used}, 0);
    @(negedge clock);
    reset = 0; start = 0;
    edge1();
    check("idle_no_start", busy, 0);
    run_cmp("c5_35", 8'hC5, 8'h35, 3'b100, 1);
    run_cmp("5a_5a", 8'h5A, 8'h5A, 3'b001, 4);
    run_cmp("5a_5b", 8'h5A, 8'h5B, 3'b010, 4);
    // start held and operands toggled while busy
    @(negedge clock);
    A = 8'h12; B = 8'h1F; start = 1;
    edge1();
    dones = 0;
    for (int i = 0; i < 4; i++) begin
      A = ~A; B = ~B;
      edge1();
      if (done) dones++;
    end
    check("hold_one_done", dones, 1);
    check("hold_flags", {A_gt_B, A_lt_B, A_eq_B}, 3'b010);
    check("hold_slices", slices_used, 3);
    check("hold_idle", {busy, done}, 2'b00);
    A = 8'hFF; B = 8'h00;
    edge1();
    start = 0;
    check("hold_restart", busy, 1);
    edge1();
    check("hold_restart_done", done, 1);
    check("hold_restart_flags", {A_gt_B, A_lt_B, A_eq_B}, 3'b100);
    edge1();
    // abort by reset on second compare edge
    @(negedge clock);
    A = 8'h00; B = 8'h01; start = 1;
    edge1();
    start = 0;
    edge1();
    check("abort_mid", {busy, done}, 2'b10);
    @(negedge clock);
    reset = 1;
    edge1();
    check("abort_reset", {busy, done, A_gt_B, A_lt_B, A_eq_B, slices_used}, 0);
    @(negedge clock);
    reset = 0;
    edge1();
    check("abort_no_done", {busy, done}, 2'b00);
    run_cmp("00_01", 8'h00, 8'h01, 3'b010, 4);
    run_cmp("12_1f", 8'h12, 8'h1F, 3'b010, 3);
`ifdef COMP_SIGNED_EN
    run_cmp("80_01", 8'h80, 8'h01, 3'b010, 1);
`else
    run_cmp("80_01", 8'h80, 8'h01, 3'b100, 1);
`endif
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
